// File: rtl/fabric_io_exerciser_pkg.sv
// rtl/fabric_io_exerciser_pkg.sv - shared types and constants for the fabric IO exerciser
// Contents:
//   state_t            run-control states
//   LFSR_W             stimulus LFSR width
//   LFSR_DEFAULT_SEED  seed used when the configured seed is zero
//   LFSR_TAP_MASK      Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 0,2,3,5)
//   ERR_W              error counter width
//   lfsr_step()        one LFSR shift
package fabric_io_exerciser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int          LFSR_W            = 16;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAP_MASK     = 16'h002D;
   localparam int          ERR_W             = 16;

   // Right-shifting Fibonacci form: the XOR of the tapped bits enters at bit 15.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {^(s & LFSR_TAP_MASK), s[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/fabric_io_lfsr16.sv
// rtl/fabric_io_lfsr16.sv - 16-bit Fibonacci LFSR for operand generation
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset (state returns to RESET_SEED)
//   i_load         load i_seed; together with i_advance loads the state one step past i_seed
//   i_seed         load value
//   i_advance      shift once
//   o_state        current LFSR state
module fabric_io_lfsr16
   import fabric_io_exerciser_pkg::*;
#(
   parameter logic [15:0] RESET_SEED = LFSR_DEFAULT_SEED
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic [LFSR_W-1:0] i_seed,
   input  logic              i_advance,
   output logic [LFSR_W-1:0] o_state
);

   logic [LFSR_W-1:0] r_state;

   // load+advance lets the parent issue the seed itself as vector 0 on the
   // start edge while the LFSR already moves on to vector 1.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= RESET_SEED;
      end else if (i_load) begin
         r_state <= i_advance ? lfsr_step(i_seed) : i_seed;
      end else if (i_advance) begin
         r_state <= lfsr_step(r_state);
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/fabric_io_exerciser.sv
// rtl/fabric_io_exerciser.sv - drives fabric operand pads and checks the registered sum returned on dst
// Optional feature macro: FABRIC_IO_EXERCISER_CAPTURE_EN (adds first-mismatch data capture ports)
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start             one-cycle pulse, starts a run from IDLE or DONE
//   o_a, o_b            registered operands to the fabric inputs
//   i_dst               result from the fabric outputs
//   o_busy              high in RUN and DRAIN
//   o_done, o_pass      run finished / finished without mismatches
//   o_err_count         saturating mismatch count
//   o_first_err_idx     vector index of the first mismatch (0 if none)
//   o_first_err_got     dst at the first mismatch (capture build only)
//   o_first_err_exp     expected value at the first mismatch (capture build only)
module fabric_io_exerciser
   import fabric_io_exerciser_pkg::*;
#(
   parameter int          DATA_WIDTH  = 8,
   parameter int unsigned NUM_VECTORS = 256,
   parameter int          EXP_LATENCY = 1,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   output logic [DATA_WIDTH-1:0] o_a,
   output logic [DATA_WIDTH-1:0] o_b,
   input  logic [DATA_WIDTH-1:0] i_dst,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_pass,
   output logic [ERR_W-1:0]      o_err_count,
   output logic [31:0]           o_first_err_idx
`ifdef FABRIC_IO_EXERCISER_CAPTURE_EN
   ,
   output logic [DATA_WIDTH-1:0] o_first_err_got,
   output logic [DATA_WIDTH-1:0] o_first_err_exp
`endif
);

   localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? LFSR_DEFAULT_SEED : LFSR_SEED;
   localparam logic [31:0] NUM_V    = 32'(NUM_VECTORS);
   localparam logic [3:0]  LAT      = 4'(EXP_LATENCY);

   state_t                r_state;
   logic [31:0]           r_issued;      // vectors issued so far in this run
   logic [3:0]            r_drain_cnt;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_pass;
   logic [ERR_W-1:0]      r_err_count;
   logic [31:0]           r_first_err_idx;
`ifdef FABRIC_IO_EXERCISER_CAPTURE_EN
   logic [DATA_WIDTH-1:0] r_first_err_got;
   logic [DATA_WIDTH-1:0] r_first_err_exp;
`endif

   // Expected-value pipeline, stage 1 loads on the same edge as o_a/o_b.
   logic                  r_pv   [1:EXP_LATENCY];
   logic [31:0]           r_pidx [1:EXP_LATENCY];
   logic [DATA_WIDTH-1:0] r_pexp [1:EXP_LATENCY];

   logic [LFSR_W-1:0]     w_lfsr;
   logic                  w_start_ok;
   logic                  w_issue_run;
   logic                  w_issue;
   logic [LFSR_W-1:0]     w_vec;
   logic [DATA_WIDTH-1:0] w_a_next;
   logic [DATA_WIDTH-1:0] w_b_next;
   logic [DATA_WIDTH-1:0] w_sum;
   logic [31:0]           w_idx;
   logic                  w_cmp_fail;

   assign w_start_ok  = i_start && ((r_state == IDLE) || (r_state == DONE));
   assign w_issue_run = (r_state == RUN) && (r_issued < NUM_V);
   assign w_issue     = w_start_ok || w_issue_run;

   // Vector 0 is the seed itself, taken directly so it is on the pads in RUN cycle 0.
   assign w_vec    = w_start_ok ? SEED_EFF : w_lfsr;
   assign w_a_next = DATA_WIDTH'(w_vec[7:0]);
   assign w_b_next = DATA_WIDTH'(w_vec[15:8]);
   assign w_sum    = w_a_next + w_b_next;
   assign w_idx    = w_start_ok ? 32'd0 : r_issued;

   assign w_cmp_fail = r_pv[EXP_LATENCY] && (i_dst != r_pexp[EXP_LATENCY]);

   fabric_io_lfsr16 #(
      .RESET_SEED (SEED_EFF)
   ) u_lfsr (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_load    (w_start_ok),
      .i_seed    (SEED_EFF),
      .i_advance (w_issue),
      .o_state   (w_lfsr)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 1; k <= EXP_LATENCY; k++) begin
            r_pv[k]   <= 1'b0;
            r_pidx[k] <= '0;
            r_pexp[k] <= '0;
         end
      end else begin
         r_pv[1]   <= w_issue;
         r_pidx[1] <= w_idx;
         r_pexp[1] <= w_sum;
         for (int k = 2; k <= EXP_LATENCY; k++) begin
            r_pv[k]   <= r_pv[k-1];
            r_pidx[k] <= r_pidx[k-1];
            r_pexp[k] <= r_pexp[k-1];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state         <= IDLE;
         r_issued        <= '0;
         r_drain_cnt     <= '0;
         r_a             <= '0;
         r_b             <= '0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_pass          <= 1'b0;
         r_err_count     <= '0;
         r_first_err_idx <= '0;
`ifdef FABRIC_IO_EXERCISER_CAPTURE_EN
         r_first_err_got <= '0;
         r_first_err_exp <= '0;
`endif
      end else begin
         if (w_issue) begin
            r_a <= w_a_next;
            r_b <= w_b_next;
         end
         if (w_issue_run) begin
            r_issued <= r_issued + 32'd1;
         end

         // A compare can only be pending in RUN/DRAIN, so it never collides
         // with the clear on a start edge below.
         if (w_cmp_fail) begin
            if (r_err_count != '1) begin
               r_err_count <= r_err_count + 1'b1;
            end
            if (r_err_count == '0) begin
               r_first_err_idx <= r_pidx[EXP_LATENCY];
`ifdef FABRIC_IO_EXERCISER_CAPTURE_EN
               r_first_err_got <= i_dst;
               r_first_err_exp <= r_pexp[EXP_LATENCY];
`endif
            end
         end

         unique case (r_state)
            IDLE, DONE: begin
               if (i_start) begin
                  r_state         <= RUN;
                  r_issued        <= 32'd1;
                  r_busy          <= 1'b1;
                  r_done          <= 1'b0;
                  r_pass          <= 1'b0;
                  r_err_count     <= '0;
                  r_first_err_idx <= '0;
`ifdef FABRIC_IO_EXERCISER_CAPTURE_EN
                  r_first_err_got <= '0;
                  r_first_err_exp <= '0;
`endif
               end
            end
            RUN: begin
               if (r_issued == NUM_V) begin
                  r_state     <= DRAIN;
                  r_drain_cnt <= 4'd1;
               end
            end
            DRAIN: begin
               // The final compare lands one edge before this transition.
               if (r_drain_cnt == LAT) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (r_err_count == '0);
               end else begin
                  r_drain_cnt <= r_drain_cnt + 4'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_a             = r_a;
   assign o_b             = r_b;
   assign o_busy          = r_busy;
   assign o_done          = r_done;
   assign o_pass          = r_pass;
   assign o_err_count     = r_err_count;
   assign o_first_err_idx = r_first_err_idx;
`ifdef FABRIC_IO_EXERCISER_CAPTURE_EN
   assign o_first_err_got = r_first_err_got;
   assign o_first_err_exp = r_first_err_exp;
`endif

endmodule

// File: doc/fabric_io_exerciser.md
Name: fabric_io_exerciser

Overview:
- Drives the fabric test design's pad-level operand buses (a, b) and checks its result bus (dst) from the other side of the IO ring.
- Used in silicon bring-up and emulation: fabric IO7..IO0 of X1Y0/X2Y0 take its a/b outputs; X1Y3 IO7..IO0 feed its dst input.
- Generates pseudo-random operand pairs and compares dst against the expected registered 8-bit sum (a+b mod 256).
- Reports an error count and the index of the first mismatch.

Parameters:
- DATA_WIDTH, 8, operand/result width (a, b, dst).
- NUM_VECTORS, 256, operand pairs per run (legal 1..2^32-1).
- EXP_LATENCY, 1, cycles from a/b launch to dst sample (legal 1..8).
- LFSR_SEED, 16'hACE1, initial LFSR state; 0 is replaced by 16'hACE1.

Ports:
- clk  in  1  single fabric-side clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- a  out  DATA_WIDTH  operand A to fabric inputs.
- b  out  DATA_WIDTH  operand B to fabric inputs.
- dst  in  DATA_WIDTH  result from fabric outputs.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE until next start.
- pass  out  1  valid when done; 1 iff err_count==0.
- err_count  out  16  mismatches, saturating at 16'hFFFF.
- first_err_idx  out  32  vector index of first mismatch; 0 if none.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, FSM=IDLE, LFSR=seed, all pipeline valid bits=0.
- FSM states:
  - IDLE: wait for start.
  - RUN: issue NUM_VECTORS vectors, one per cycle.
  - DRAIN: EXP_LATENCY cycles; compare only, no new vectors.
  - DONE: hold results; start returns to RUN.
- Run start: start in IDLE or DONE clears counters, err_count and first_err_idx, reloads the LFSR seed, and enters RUN on the next edge.
- start in RUN or DRAIN is ignored.
- Stimulus: 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
  - Vector i: a=lfsr[7:0], b=lfsr[15:8], registered.
  - Vector i appears on a/b in the i-th cycle of RUN; the LFSR advances once per issued vector.
  - a/b hold their last value through DRAIN and DONE.
- Expected path: {valid, idx, (a+b) mod 2^DATA_WIDTH} enters an EXP_LATENCY-deep shift register alongside the issue.
  - The stage-EXP_LATENCY entry is compared with the dst sampled on that same edge.
  - No carry-out is checked.
- Mismatch handling: increment err_count, saturating at 0xFFFF.
  - On the first mismatch of a run, latch first_err_idx=idx.
  - Later mismatches do not change first_err_idx.
- RUN→DRAIN: after vector NUM_VECTORS-1 is issued.
- DRAIN→DONE: after EXP_LATENCY cycles, once the last compare has completed.
- In DONE: done=1, pass=(err_count==0). done is cleared on the start edge.
- NUM_VECTORS=1: one RUN cycle, then DRAIN.
- Counters: the 32-bit vector counter never wraps within a run.
- Reset mid-run: immediate abort to the reset state; no partial results are kept.

Optional Feature:
- FABRIC_IO_EXERCISER_CAPTURE_EN defined:
  - Adds outputs first_err_got[DATA_WIDTH] and first_err_exp[DATA_WIDTH].
  - They latch dst and the expected value at the first mismatch.
  - Reset and cleared on start with the other results.
- Macro undefined: the ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package fabric_io_exerciser_pkg:
  - State enum (IDLE, RUN, DRAIN, DONE).
  - LFSR width 16, default seed 16'hACE1, tap mask, err_count width 16.
- Sub-module fabric_io_lfsr16:
  - Inputs: load, seed, advance.
  - Output: 16-bit state.
  - Same reset style as the parent.
- The FSM, expected-value pipeline and compare stay in the parent.

Test Plan:
- Loopback model, registered adder, latency 1; NUM_VECTORS=256, EXP_LATENCY=1 → done after 256+1 cycles, pass=1, err_count=0; first a=8'hE1, b=8'hAC.
- Model corrupts dst for vector 5 only (XOR 8'h01) → err_count=1, first_err_idx=5, pass=0; with CAPTURE_EN, first_err_got = first_err_exp^8'h01.
- Model latency 2 with EXP_LATENCY=1 → pass=0, err_count>200, first_err_idx=0; retest with EXP_LATENCY=2 → pass=1.
- Assert rst during RUN at vector 100 → all outputs are reset values the same cycle; a fresh start reproduces a=8'hE1, b=8'hAC first.
- Pulse start at RUN cycle 10 → ignored, vector sequence and done timing unchanged; start in DONE → counters cleared, identical second run.
- dst = ~expected for all vectors, NUM_VECTORS=70000 → err_count saturates at 16'hFFFF, first_err_idx=0, done after 70000+EXP_LATENCY cycles.
